// File: rtl/elbeth_pipeline_pkg.sv
// Shared definitions for the ELBETH pipeline control path: exception FSM states,
// PC source encodings and exception cause codes (also used by elbeth_if_id_register).
package elbeth_pipeline_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_DRAIN    = 2'd1,
        ST_REDIRECT = 2'd2
    } exc_state_e;

    typedef logic [1:0] pc_sel_t;
    typedef logic [3:0] exc_cause_t;

    localparam pc_sel_t PC_SEL_SEQ    = 2'd0;
    localparam pc_sel_t PC_SEL_BRANCH = 2'd1;
    localparam pc_sel_t PC_SEL_EXC    = 2'd2;

    localparam exc_cause_t EXC_INSTR_MISALIGN = 4'h0;
    localparam exc_cause_t EXC_INSTR_FAULT    = 4'h1;
    localparam exc_cause_t EXC_ILLEGAL_INSTR  = 4'h2;
    localparam exc_cause_t EXC_BREAKPOINT     = 4'h3;
    localparam exc_cause_t EXC_LOAD_MISALIGN  = 4'h4;
    localparam exc_cause_t EXC_LOAD_FAULT     = 4'h5;
    localparam exc_cause_t EXC_STORE_MISALIGN = 4'h6;
    localparam exc_cause_t EXC_STORE_FAULT    = 4'h7;
    localparam exc_cause_t EXC_ECALL          = 4'h8;

endpackage

// File: rtl/elbeth_hazard_detect.sv
// Load-use hazard compare: a load in EX whose destination feeds either ID source.
// x0 is hardwired to zero, so it never creates a dependency.
module elbeth_hazard_detect #(
    parameter int REG_ADDR_W = 5
) (
    input  logic [REG_ADDR_W-1:0] id_rs1_addr,
    input  logic [REG_ADDR_W-1:0] id_rs2_addr,
    input  logic [REG_ADDR_W-1:0] ex_rd_addr,
    input  logic                  ex_mem_read,
    output logic                  load_use_o
);

    assign load_use_o = ex_mem_read && (ex_rd_addr != '0) &&
                        ((ex_rd_addr == id_rs1_addr) || (ex_rd_addr == id_rs2_addr));

endmodule

// File: rtl/elbeth_pipeline_ctrl.sv
// Stall/flush sequencer for the five-stage ELBETH pipeline; exception entry runs
// through RUN -> (DRAIN) -> REDIRECT, and cycles with the PC held are counted.
module elbeth_pipeline_ctrl
    import elbeth_pipeline_pkg::*;
#(
    parameter int EXC_DRAIN_MAX = 15,
    parameter int REG_ADDR_W    = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_imem_ready,
    input  logic                  mem_dmem_ready,
    input  logic [REG_ADDR_W-1:0] id_rs1_addr,
    input  logic [REG_ADDR_W-1:0] id_rs2_addr,
    input  logic [REG_ADDR_W-1:0] ex_rd_addr,
    input  logic                  ex_mem_read,
    input  logic                  ex_branch_taken,
    input  logic                  ex_mdu_busy,
    input  logic                  mem_except_valid,
    input  logic [3:0]            mem_except_source,
    output logic                  pc_stall,
    output logic                  if_id_stall,
    output logic                  if_id_flush,
    output logic                  id_ex_stall,
    output logic                  id_ex_flush,
    output logic                  ex_mem_stall,
    output logic                  ex_mem_flush,
    output logic                  mem_wb_flush,
    output logic [1:0]            pc_sel,
    output logic [3:0]            except_cause,
    output logic                  except_pending,
    output logic [31:0]           stall_count
);

    exc_state_e state_q, state_d;
    exc_cause_t cause_q, cause_d;
    logic [3:0] drain_q, drain_d;
    logic [31:0] stall_count_q;
    logic load_use;

    elbeth_hazard_detect #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_hazard (
        .id_rs1_addr (id_rs1_addr),
        .id_rs2_addr (id_rs2_addr),
        .ex_rd_addr  (ex_rd_addr),
        .ex_mem_read (ex_mem_read),
        .load_use_o  (load_use)
    );

    always_comb begin
        state_d      = state_q;
        cause_d      = cause_q;
        drain_d      = drain_q;
        pc_stall     = 1'b0;
        if_id_stall  = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_stall  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_stall = 1'b0;
        ex_mem_flush = 1'b0;
        mem_wb_flush = 1'b0;
        pc_sel       = PC_SEL_SEQ;

        unique case (state_q)
            ST_RUN: begin
                drain_d = '0;
                if (mem_except_valid) begin
                    cause_d      = mem_except_source;
                    pc_stall     = 1'b1;
                    if_id_flush  = 1'b1;
                    id_ex_flush  = 1'b1;
                    ex_mem_flush = 1'b1;
                    state_d      = mem_dmem_ready ? ST_REDIRECT : ST_DRAIN;
                end else if (!mem_dmem_ready) begin
                    pc_stall     = 1'b1;
                    if_id_stall  = 1'b1;
                    id_ex_stall  = 1'b1;
                    ex_mem_stall = 1'b1;
                    mem_wb_flush = 1'b1;
                end else if (ex_mdu_busy) begin
                    pc_stall     = 1'b1;
                    if_id_stall  = 1'b1;
                    id_ex_stall  = 1'b1;
                    ex_mem_flush = 1'b1;
                end else if (ex_branch_taken) begin
                    pc_sel       = PC_SEL_BRANCH;
                    if_id_flush  = 1'b1;
                    id_ex_flush  = 1'b1;
                end else if (load_use) begin
                    pc_stall     = 1'b1;
                    if_id_stall  = 1'b1;
                    id_ex_flush  = 1'b1;
                end else if (!if_imem_ready) begin
                    pc_stall     = 1'b1;
                    if_id_flush  = 1'b1;
                end
            end
            ST_DRAIN: begin
                // Further exceptions are ignored here so the first cause survives.
                pc_stall     = 1'b1;
                if_id_flush  = 1'b1;
                id_ex_flush  = 1'b1;
                ex_mem_flush = 1'b1;
                drain_d      = drain_q + 4'd1;
                if (mem_dmem_ready || (drain_d == 4'(EXC_DRAIN_MAX))) begin
                    state_d = ST_REDIRECT;
                end
            end
            ST_REDIRECT: begin
                pc_sel       = PC_SEL_EXC;
                if_id_flush  = 1'b1;
                id_ex_flush  = 1'b1;
                ex_mem_flush = 1'b1;
                mem_wb_flush = 1'b1;
                drain_d      = '0;
                state_d      = ST_RUN;
            end
            default: begin
                state_d = ST_RUN;
                drain_d = '0;
            end
        endcase

        // Reset flushes every stage register and suppresses any pending redirect.
        if (rst) begin
            pc_stall     = 1'b0;
            if_id_stall  = 1'b0;
            id_ex_stall  = 1'b0;
            ex_mem_stall = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
            mem_wb_flush = 1'b1;
            pc_sel       = PC_SEL_SEQ;
        end
    end

    assign except_pending = !rst && (state_q != ST_RUN);
    assign except_cause   = rst ? 4'h0 : cause_q;
    assign stall_count    = stall_count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_RUN;
            cause_q       <= '0;
            drain_q       <= '0;
            stall_count_q <= '0;
        end else begin
            state_q       <= state_d;
            cause_q       <= cause_d;
            drain_q       <= drain_d;
            stall_count_q <= stall_count_q + {31'd0, pc_stall};
        end
    end

endmodule

// File: tb/tb_elbeth_pipeline_ctrl.sv
// Randomized and directed bench for elbeth_pipeline_ctrl against a cycle-level
// behavioural model of the stall/flush rules and exception sequencing.
module tb_elbeth_pipeline_ctrl;

    localparam int RW = 5;
    localparam int DRAIN_MAX = 15;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_imem_ready, mem_dmem_ready;
    logic [RW-1:0] id_rs1_addr, id_rs2_addr, ex_rd_addr;
    logic          ex_mem_read, ex_branch_taken, ex_mdu_busy, mem_except_valid;
    logic [3:0]    mem_except_source;
    logic          pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush;
    logic          ex_mem_stall, ex_mem_flush, mem_wb_flush, except_pending;
    logic [1:0]    pc_sel;
    logic [3:0]    except_cause;
    logic [31:0]   stall_count;

    int n_checks = 0;
    int n_errors = 0;

    // Model state: phase 0 = normal flow, 1 = waiting for memory before the
    // vector jump, 2 = vector jump cycle.
    int          m_phase;
    int          m_waited;
    logic [3:0]  m_cause;
    logic [31:0] m_count;

    always #5 clk = ~clk;

    elbeth_pipeline_ctrl #(
        .EXC_DRAIN_MAX (DRAIN_MAX),
        .REG_ADDR_W    (RW)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .if_imem_ready     (if_imem_ready),
        .mem_dmem_ready    (mem_dmem_ready),
        .id_rs1_addr       (id_rs1_addr),
        .id_rs2_addr       (id_rs2_addr),
        .ex_rd_addr        (ex_rd_addr),
        .ex_mem_read       (ex_mem_read),
        .ex_branch_taken   (ex_branch_taken),
        .ex_mdu_busy       (ex_mdu_busy),
        .mem_except_valid  (mem_except_valid),
        .mem_except_source (mem_except_source),
        .pc_stall          (pc_stall),
        .if_id_stall       (if_id_stall),
        .if_id_flush       (if_id_flush),
        .id_ex_stall       (id_ex_stall),
        .id_ex_flush       (id_ex_flush),
        .ex_mem_stall      (ex_mem_stall),
        .ex_mem_flush      (ex_mem_flush),
        .mem_wb_flush      (mem_wb_flush),
        .pc_sel            (pc_sel),
        .except_cause      (except_cause),
        .except_pending    (except_pending),
        .stall_count       (stall_count)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, act, exp);
        end
    endtask

    task automatic set_idle();
        rst = 0; if_imem_ready = 1; mem_dmem_ready = 1;
        id_rs1_addr = 0; id_rs2_addr = 0; ex_rd_addr = 0;
        ex_mem_read = 0; ex_branch_taken = 0; ex_mdu_busy = 0;
        mem_except_valid = 0; mem_except_source = 0;
    endtask

    // Inputs are applied right after a falling edge; check and advance the model.
    task automatic step();
        logic e_pcs, e_ifs, e_iff, e_ids, e_idf, e_exs, e_exf, e_wbf, e_pend;
        logic [1:0] e_sel;
        logic [3:0] e_cause;
        logic lu;
        #1;
        {e_pcs, e_ifs, e_iff, e_ids, e_idf, e_exs, e_exf, e_wbf} = '0;
        e_sel = 2'd0;
        lu = ex_mem_read && ex_rd_addr != 0 &&
             (ex_rd_addr == id_rs1_addr || ex_rd_addr == id_rs2_addr);
        if (rst) begin
            {e_iff, e_idf, e_exf, e_wbf} = 4'b1111;
        end else if (m_phase == 2) begin
            e_sel = 2'd2;
            {e_iff, e_idf, e_exf, e_wbf} = 4'b1111;
        end else if (m_phase == 1) begin
            {e_pcs, e_iff, e_idf, e_exf} = 4'b1111;
        end else if (mem_except_valid) begin
            {e_pcs, e_iff, e_idf, e_exf} = 4'b1111;
        end else if (!mem_dmem_ready) begin
            {e_pcs, e_ifs, e_ids, e_exs, e_wbf} = 5'b11111;
        end else if (ex_mdu_busy) begin
            {e_pcs, e_ifs, e_ids, e_exf} = 4'b1111;
        end else if (ex_branch_taken) begin
            e_sel = 2'd1;
            {e_iff, e_idf} = 2'b11;
        end else if (lu) begin
            {e_pcs, e_ifs, e_idf} = 3'b111;
        end else if (!if_imem_ready) begin
            {e_pcs, e_iff} = 2'b11;
        end
        e_pend  = !rst && m_phase != 0;
        e_cause = rst ? 4'h0 : m_cause;

        chk("pc_stall",       pc_stall,       e_pcs);
        chk("if_id_stall",    if_id_stall,    e_ifs);
        chk("if_id_flush",    if_id_flush,    e_iff);
        chk("id_ex_stall",    id_ex_stall,    e_ids);
        chk("id_ex_flush",    id_ex_flush,    e_idf);
        chk("ex_mem_stall",   ex_mem_stall,   e_exs);
        chk("ex_mem_flush",   ex_mem_flush,   e_exf);
        chk("mem_wb_flush",   mem_wb_flush,   e_wbf);
        chk("pc_sel",         pc_sel,         e_sel);
        chk("except_pending", except_pending, e_pend);
        chk("except_cause",   except_cause,   e_cause);
        chk("stall_count",    stall_count,    m_count);

        if (rst) begin
            m_phase = 0; m_waited = 0; m_cause = 0; m_count = 0;
        end else begin
            m_count = m_count + (e_pcs ? 32'd1 : 32'd0);
            if (m_phase == 2) begin
                m_phase = 0;
            end else if (m_phase == 1) begin
                m_waited++;
                if (mem_dmem_ready || m_waited >= DRAIN_MAX) m_phase = 2;
            end else if (mem_except_valid) begin
                m_cause  = mem_except_source;
                m_waited = 0;
                m_phase  = mem_dmem_ready ? 2 : 1;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        m_phase = 0; m_waited = 0; m_cause = 0; m_count = 0;
        set_idle();
        rst = 1;
        @(negedge clk);
        step(); step();
        set_idle();
        step(); step();

        // Load-use on rs2, then the same with x0 as destination.
        ex_mem_read = 1; ex_rd_addr = 5; id_rs2_addr = 5; id_rs1_addr = 7;
        step();
        ex_rd_addr = 0; id_rs2_addr = 0;
        step();
        set_idle();

        // Branch taken alongside a load-use hazard.
        ex_branch_taken = 1; ex_mem_read = 1; ex_rd_addr = 3; id_rs1_addr = 3;
        step();
        set_idle();

        // Data-memory wait of three cycles.
        mem_dmem_ready = 0;
        repeat (3) step();
        set_idle();
        step();

        // Exception with memory ready.
        mem_except_valid = 1; mem_except_source = 4'h5;
        step();
        set_idle();
        repeat (3) step();

        // Exception while memory is stuck, with a second exception mid-drain.
        mem_dmem_ready = 0; mem_except_valid = 1; mem_except_source = 4'h3;
        step();
        mem_except_valid = 0;
        for (int i = 0; i < 20; i++) begin
            mem_except_valid  = (i == 5);
            mem_except_source = (i == 5) ? 4'h9 : 4'h0;
            step();
        end
        set_idle();
        repeat (2) step();

        // Reset while draining.
        mem_dmem_ready = 0; mem_except_valid = 1; mem_except_source = 4'h7;
        step();
        mem_except_valid = 0;
        repeat (4) step();
        rst = 1;
        step();
        set_idle();
        repeat (3) step();

        // Random traffic with small register indices so hazards are frequent.
        for (int c = 0; c < 3000; c++) begin
            rst               = ($urandom_range(0, 199) == 0);
            if_imem_ready     = ($urandom_range(0, 4) != 0);
            mem_dmem_ready    = ($urandom_range(0, 3) != 0);
            id_rs1_addr       = RW'($urandom_range(0, 3));
            id_rs2_addr       = RW'($urandom_range(0, 3));
            ex_rd_addr        = RW'($urandom_range(0, 3));
            ex_mem_read       = $urandom_range(0, 1) == 1;
            ex_branch_taken   = ($urandom_range(0, 3) == 0);
            ex_mdu_busy       = ($urandom_range(0, 5) == 0);
            mem_except_valid  = ($urandom_range(0, 19) == 0);
            mem_except_source = 4'($urandom_range(0, 15));
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/elbeth_pipeline_ctrl.md
Name: elbeth_pipeline_ctrl

Overview:
Central stall/flush sequencer for the five-stage ELBETH pipeline (IF, ID, EX, MEM, WB). It drives the ctrl_stall/ctrl_flush pairs of every inter-stage register and the PC-source select, resolving load-use hazards, taken branches, memory wait states, multi-cycle MDU operations and exceptions. Exception entry is sequenced by a small FSM; a stall-cycle counter supports performance measurement.

Parameters:
EXC_DRAIN_MAX, 15, cycles DRAIN waits for mem_dmem_ready before forcing redirect (4-bit counter)
REG_ADDR_W, 5, register-file address width

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
if_imem_ready  in  1  instruction memory data valid this cycle
mem_dmem_ready  in  1  data memory access complete (1 when MEM has no access)
id_rs1_addr  in  REG_ADDR_W  ID source 1
id_rs2_addr  in  REG_ADDR_W  ID source 2
ex_rd_addr  in  REG_ADDR_W  EX destination
ex_mem_read  in  1  EX instruction is a load
ex_branch_taken  in  1  EX resolved taken branch/jump
ex_mdu_busy  in  1  multiply/divide unit not finished
mem_except_valid  in  1  exception raised in MEM
mem_except_source  in  4  exception cause from MEM
pc_stall  out  1  hold PC
if_id_stall  out  1  ctrl_stall for IF/ID
if_id_flush  out  1  ctrl_flush for IF/ID
id_ex_stall  out  1  ctrl_stall for ID/EX
id_ex_flush  out  1  ctrl_flush for ID/EX
ex_mem_stall  out  1  ctrl_stall for EX/MEM
ex_mem_flush  out  1  ctrl_flush for EX/MEM
mem_wb_flush  out  1  ctrl_flush for MEM/WB
pc_sel  out  2  0 PC+4, 1 branch target, 2 exception vector
except_cause  out  4  latched cause, valid while except_pending
except_pending  out  1  FSM outside RUN
stall_count  out  32  total cycles with pc_stall=1

Behaviour:
- Control outputs combinational from inputs and FSM state; FSM, cause, drain counter, stall_count registered.
- Register semantics (owned by stage registers): flush dominates stall.
- During rst: all flushes 1, all stalls 0, pc_sel=0, except_pending=0, except_cause=0; state<=RUN, stall_count<=0, drain counter<=0.
- FSM states: RUN, DRAIN, REDIRECT.
- RUN, priority high to low:
  1. mem_except_valid: latch cause; ex_mem_flush=1, id_ex_flush=1, if_id_flush=1, pc_stall=1; next DRAIN if !mem_dmem_ready, else REDIRECT.
  2. !mem_dmem_ready: pc_stall, if_id_stall, id_ex_stall, ex_mem_stall=1; mem_wb_flush=1 (bubble into WB).
  3. ex_mdu_busy: pc_stall, if_id_stall, id_ex_stall=1; ex_mem_flush=1.
  4. ex_branch_taken: pc_sel=1, if_id_flush=1, id_ex_flush=1.
  5. Load-use: ex_mem_read && ex_rd_addr!=0 && (ex_rd_addr==id_rs1_addr || ex_rd_addr==id_rs2_addr): pc_stall, if_id_stall=1; id_ex_flush=1.
  6. !if_imem_ready: pc_stall=1; if_id_flush=1.
  7. Otherwise all 0, pc_sel=0.
- DRAIN: pc_stall=1, if_id_flush, id_ex_flush, ex_mem_flush=1; drain counter increments each cycle; go REDIRECT when mem_dmem_ready or counter==EXC_DRAIN_MAX. A second mem_except_valid is ignored (cause not overwritten).
- REDIRECT (exactly 1 cycle): pc_sel=2, all four flushes=1, pc_stall=0; next RUN; drain counter cleared.
- except_pending=1 in DRAIN and REDIRECT; except_cause holds until next exception.
- stall_count += 1 on every cycle pc_stall=1; wraps 0xFFFFFFFF->0.
- rst mid-DRAIN/REDIRECT: RUN next cycle; no redirect issued.
- Register 0 never causes load-use stall.

Decomposition:
- elbeth_pipeline_pkg: FSM state encodings, PC_SEL_{SEQ,BRANCH,EXC}, exception cause codes shared with elbeth_if_id_register's except_source.
- Sub-module elbeth_hazard_detect: combinational load-use compare; rest stays in top.

Test Plan:
- Load-use: ex_mem_read=1, ex_rd_addr=5, id_rs2_addr=5 -> 1 cycle pc_stall=1, if_id_stall=1, id_ex_flush=1; ex_rd_addr=0 -> no stall.
- Branch: ex_branch_taken=1 -> pc_sel=1, if_id_flush=id_ex_flush=1 same cycle; with concurrent load-use, branch wins (no stall).
- Dmem wait: mem_dmem_ready=0 for 3 cycles -> pc/if_id/id_ex/ex_mem stalls high 3 cycles, mem_wb_flush=1; stall_count +3.
- Exception with ready: mem_except_valid=1, source=4'h5 -> next cycle REDIRECT, pc_sel=2, all flushes 1, except_cause=5; then RUN.
- Exception during dmem wait: ready low 20 cycles -> DRAIN 15 cycles, then forced REDIRECT; second exception mid-DRAIN keeps original cause.
- rst asserted in DRAIN -> next cycle RUN, pc_sel=0, stall_count=0, except_pending=0.
